dac_write_arbiter: RTL

Round-robin arbiter and sequencer sharing the single SPI DAC writer (MCP4911 path, 10-bit data) between two sample producers. It grants one requester at a time, presents that requester's word on the DAC data bus, pulses the writer's load input, and tracks the writer's chip-select to detect frame start and completion. A watchdog recovers the arbiter if a frame never starts or never finishes. It sits between the signal-generation blocks and the SPI DAC writer, in the 50 MHz `sysclk` domain.

---
 rtl/dac_write_arbiter_if.sv | 32 +++
 rtl/dac_write_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter_if.sv
// Signal bundle shared by the two sample producers, the write arbiter and
// the SPI DAC writer. The arbiter connects through the master modport; the
// producers and the writer (or a bench model of them) use the slave modport.
interface dac_write_arbiter_if #(
  parameter int unsigned DW = 10
) ();
  logic          req0;
  logic [DW-1:0] data0;
  logic          ack0;
  logic          req1;
  logic [DW-1:0] data1;
  logic          ack1;
  logic [DW-1:0] dac_data;
  logic          dac_load;
  logic          dac_cs;
  logic          busy;
  logic          grant_id;
  logic          timeout_err;
  logic          err_clr;

  // Arbiter side: consumes requests and chip-select, drives grants and the DAC word.
  modport master (
    input  req0, data0, req1, data1, dac_cs, err_clr,
    output ack0, ack1, dac_data, dac_load, busy, grant_id, timeout_err
  );

  // Producer / writer side: the mirror image of the arbiter view.
  modport slave (
    output req0, data0, req1, data1, dac_cs, err_clr,
    input  ack0, ack1, dac_data, dac_load, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter that shares one SPI DAC writer between two sample
// producers. It grants one requester, latches its word onto dac_data, pulses
// dac_load/ack for one cycle, then follows the writer's chip-select through a
// full frame. A watchdog returns the FSM to IDLE if the frame never starts or
// never finishes, leaving a sticky timeout_err behind.
module dac_write_arbiter #(
  parameter int unsigned DW      = 10,
  parameter logic [11:0] TIMEOUT = 12'd4095
) (
  input logic                 sysclk,
  input logic                 reset,
  dac_write_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_LOAD         = 3'd1,
    ST_WAIT_CS_LOW  = 3'd2,
    ST_WAIT_CS_HIGH = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          gid_q, gid_d;
  logic          load_q, load_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          any_req_s;
  logic          sel_s;
  logic          cnt_hit_s;

  // A lone request wins outright; on a tie the requester that was not
  // granted last wins, so grant_id doubles as the round-robin pointer.
  assign any_req_s = bus.req0 | bus.req1;
  assign sel_s     = (bus.req0 & bus.req1) ? ~gid_q : bus.req1;
  assign cnt_hit_s = (cnt_q == TIMEOUT);

  // Next-state, watchdog and registered-output decode for the grant sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gid_d   = gid_q;
    load_d  = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    // A watchdog set below overrides this clear in the same cycle.
    err_d   = bus.err_clr ? 1'b0 : err_q;
    case (state_q)
      ST_IDLE: begin
        // dac_cs must read high so a frame left running across reset is not cut into.
        if (any_req_s && bus.dac_cs) begin
          state_d = ST_LOAD;
          data_d  = sel_s ? bus.data1 : bus.data0;
          gid_d   = sel_s;
          load_d  = 1'b1;
          ack0_d  = ~sel_s;
          ack1_d  = sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d   = 12'd0;
        state_d = ST_WAIT_CS_LOW;
      end
      ST_WAIT_CS_LOW: begin
        if (cnt_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.dac_cs) begin
          // Restart the count so the frame itself has the full budget.
          cnt_d   = 12'd0;
          state_d = ST_WAIT_CS_HIGH;
        end else begin
          cnt_d   = cnt_q + 12'd1;
        end
      end
      ST_WAIT_CS_HIGH: begin
        if (cnt_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.dac_cs) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered from the next state so busy rises together with dac_load.
    busy_d = (state_d != ST_IDLE);
  end

  // State register and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 12'd0;
      data_q  <= {DW{1'b0}};
      gid_q   <= 1'b1;
      load_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      load_q  <= load_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.dac_data    = data_q;
  assign bus.dac_load    = load_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = gid_q;
  assign bus.timeout_err = err_q;

endmodule
